// File: rtl/pulse_envelope_length_if.sv
// rtl/pulse_envelope_length_if.sv - CPU register write bus into the pulse envelope/length block
interface pulse_envelope_length_if;
    logic       iWriteCtrl;
    logic       iWriteLength;
    logic [7:0] iData;

    modport master (output iWriteCtrl, output iWriteLength, output iData);
    modport slave  (input  iWriteCtrl, input  iWriteLength, input  iData);
endinterface

// File: rtl/pulse_envelope_length.sv
// rtl/pulse_envelope_length.sv - pulse channel envelope, length counter and sample output stage
module pulse_envelope_length #(
    parameter int LEN_W = 8,
    parameter int VOL_W = 4
) (
    input  logic                        clk,
    input  logic                        iReset,
    input  logic                        iDuty,
    input  logic                        iEnable,
    input  logic                        iQuarterFrame,
    input  logic                        iHalfFrame,
    pulse_envelope_length_if.slave      iBus,
    output logic [VOL_W-1:0]            oSample,
    output logic                        oLengthActive
);

    localparam logic [VOL_W-1:0] DECAY_MAX = {VOL_W{1'b1}};

    logic             r_ctrl_halt;
    logic             r_ctrl_const;
    logic [VOL_W-1:0] r_ctrl_vol;
    logic             r_start_flag;
    logic [VOL_W-1:0] r_divider;
    logic [VOL_W-1:0] r_decay;
    logic [LEN_W-1:0] r_length;
    logic [VOL_W-1:0] r_sample;
    logic             r_length_active;

    logic             w_len_nz;
    logic [LEN_W-1:0] w_lut_len;
    logic [VOL_W-1:0] w_volume;

    function automatic logic [7:0] len_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  len_lut = 8'd10;   5'd1:  len_lut = 8'd254;
            5'd2:  len_lut = 8'd20;   5'd3:  len_lut = 8'd2;
            5'd4:  len_lut = 8'd40;   5'd5:  len_lut = 8'd4;
            5'd6:  len_lut = 8'd80;   5'd7:  len_lut = 8'd6;
            5'd8:  len_lut = 8'd160;  5'd9:  len_lut = 8'd8;
            5'd10: len_lut = 8'd60;   5'd11: len_lut = 8'd10;
            5'd12: len_lut = 8'd14;   5'd13: len_lut = 8'd12;
            5'd14: len_lut = 8'd26;   5'd15: len_lut = 8'd14;
            5'd16: len_lut = 8'd12;   5'd17: len_lut = 8'd16;
            5'd18: len_lut = 8'd24;   5'd19: len_lut = 8'd18;
            5'd20: len_lut = 8'd48;   5'd21: len_lut = 8'd20;
            5'd22: len_lut = 8'd96;   5'd23: len_lut = 8'd22;
            5'd24: len_lut = 8'd192;  5'd25: len_lut = 8'd24;
            5'd26: len_lut = 8'd72;   5'd27: len_lut = 8'd26;
            5'd28: len_lut = 8'd16;   5'd29: len_lut = 8'd28;
            5'd30: len_lut = 8'd32;   default: len_lut = 8'd30;
        endcase
    endfunction

    always_comb begin
        w_len_nz  = (r_length != '0);
        w_lut_len = LEN_W'(len_lut(iBus.iData[7:3]));
        w_volume  = r_ctrl_const ? r_ctrl_vol : r_decay;
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_ctrl_halt     <= 1'b0;
            r_ctrl_const    <= 1'b0;
            r_ctrl_vol      <= '0;
            r_start_flag    <= 1'b0;
            r_divider       <= '0;
            r_decay         <= '0;
            r_length        <= '0;
            r_sample        <= '0;
            r_length_active <= 1'b0;
        end else begin
            if (iBus.iWriteCtrl) begin
                r_ctrl_halt  <= iBus.iData[5];
                r_ctrl_const <= iBus.iData[4];
                r_ctrl_vol   <= iBus.iData[VOL_W-1:0];
            end

            // Ticks read the pre-write ctrl/start values; a length write re-arms start afterwards.
            if (iQuarterFrame) begin
                if (r_start_flag) begin
                    r_start_flag <= 1'b0;
                    r_decay      <= DECAY_MAX;
                    r_divider    <= r_ctrl_vol;
                end else if (r_divider == '0) begin
                    r_divider <= r_ctrl_vol;
                    if (r_decay != '0)
                        r_decay <= r_decay - VOL_W'(1);
                    else if (r_ctrl_halt)
                        r_decay <= DECAY_MAX;
                end else begin
                    r_divider <= r_divider - VOL_W'(1);
                end
            end
            if (iBus.iWriteLength)
                r_start_flag <= 1'b1;

            // Disable beats load, load beats decrement.
            if (!iEnable)
                r_length <= '0;
            else if (iBus.iWriteLength)
                r_length <= w_lut_len;
            else if (iHalfFrame && !r_ctrl_halt && w_len_nz)
                r_length <= r_length - LEN_W'(1);

            r_sample        <= (iDuty && w_len_nz) ? w_volume : '0;
            r_length_active <= w_len_nz;
        end
    end

    assign oSample       = r_sample;
    assign oLengthActive = r_length_active;

endmodule

// File: tb/tb_pulse_envelope_length.sv
// tb/tb_pulse_envelope_length.sv - directed scoreboard bench for pulse_envelope_length
module tb_pulse_envelope_length;

    logic       clk = 1'b0;
    logic       iReset;
    logic       iDuty;
    logic       iEnable;
    logic       iQuarterFrame;
    logic       iHalfFrame;
    logic [3:0] oSample;
    logic       oLengthActive;

    pulse_envelope_length_if u_bus ();

    pulse_envelope_length #(.LEN_W(8), .VOL_W(4)) u_dut (
        .clk           (clk),
        .iReset        (iReset),
        .iDuty         (iDuty),
        .iEnable       (iEnable),
        .iQuarterFrame (iQuarterFrame),
        .iHalfFrame    (iHalfFrame),
        .iBus          (u_bus),
        .oSample       (oSample),
        .oLengthActive (oLengthActive)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] sample;
        logic       active;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input string tag, input int sample, input logic active);
        exp_t e;
        e.tag    = tag;
        e.sample = 4'(sample);
        e.active = active;
        q.push_back(e);
    endtask

    // Every expectation pushed since the previous edge is due right after this edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            assert ({oSample, oLengthActive} === {e.sample, e.active}) else begin
                fails++;
                $error("FAIL %s: got sample=%0d active=%0b, expected sample=%0d active=%0b",
                       e.tag, oSample, oLengthActive, e.sample, e.active);
            end
        end
    endtask

    task automatic wr_ctrl(input logic [7:0] d);
        u_bus.iWriteCtrl = 1'b1;
        u_bus.iData      = d;
        cycle();
        u_bus.iWriteCtrl = 1'b0;
    endtask

    task automatic wr_len(input logic [7:0] d);
        u_bus.iWriteLength = 1'b1;
        u_bus.iData        = d;
        cycle();
        u_bus.iWriteLength = 1'b0;
    endtask

    task automatic qtick();
        iQuarterFrame = 1'b1;
        cycle();
        iQuarterFrame = 1'b0;
    endtask

    task automatic htick();
        iHalfFrame = 1'b1;
        cycle();
        iHalfFrame = 1'b0;
    endtask

    initial begin
        iReset             = 1'b1;
        iDuty              = 1'b0;
        iEnable            = 1'b0;
        iQuarterFrame      = 1'b0;
        iHalfFrame         = 1'b0;
        u_bus.iWriteCtrl   = 1'b0;
        u_bus.iWriteLength = 1'b0;
        u_bus.iData        = 8'h00;
        cycle();
        push("reset", 0, 1'b0);
        cycle();
        iReset = 1'b0;

        // Constant volume
        iEnable = 1'b1;
        iDuty   = 1'b1;
        wr_ctrl(8'h1A);
        push("len_pre_load", 0, 1'b0);
        wr_len(8'h08);
        push("const_vol", 10, 1'b1);
        cycle();
        iDuty = 1'b0;
        push("duty_off", 0, 1'b1);
        cycle();
        iDuty = 1'b1;

        // Envelope, period 3, no loop
        wr_ctrl(8'h03);
        wr_len(8'h08);
        for (int n = 1; n <= 64; n++) begin
            int exp_d;
            if (n == 1)
                exp_d = 15;
            else if ((n - 1) / 4 >= 15)
                exp_d = 0;
            else
                exp_d = 15 - (n - 1) / 4;
            qtick();
            push($sformatf("env_p3_tick%0d", n), exp_d, 1'b1);
            cycle();
        end

        // Envelope, period 0, looping
        wr_ctrl(8'h20);
        wr_len(8'h08);
        for (int n = 1; n <= 18; n++) begin
            int exp_d;
            exp_d = (n == 1) ? 15 : (32 - n) % 16;
            qtick();
            push($sformatf("env_loop_tick%0d", n), exp_d, 1'b1);
            cycle();
        end

        // Length expiry, halt clear
        wr_ctrl(8'h13);
        wr_len(8'h18);
        push("len2_loaded", 3, 1'b1);
        cycle();
        htick();
        push("len2_half1", 3, 1'b1);
        cycle();
        htick();
        push("len_expired", 0, 1'b0);
        cycle();
        htick();
        push("len_no_wrap", 0, 1'b0);
        cycle();

        // Length halted
        wr_ctrl(8'h33);
        wr_len(8'h18);
        push("halt_loaded", 3, 1'b1);
        cycle();
        htick();
        htick();
        push("halt_hold", 3, 1'b1);
        cycle();

        // Channel disable
        iEnable = 1'b0;
        cycle();
        wr_len(8'h08);
        push("en0_load_ignored", 0, 1'b0);
        cycle();
        iEnable = 1'b1;
        wr_len(8'h08);
        push("en1_load", 3, 1'b1);
        cycle();
        iEnable = 1'b0;
        push("en_drop_a", 3, 1'b1);
        cycle();
        push("en_drop_b", 0, 1'b0);
        cycle();
        iEnable = 1'b1;

        // Load coincident with half-frame while length=5
        wr_ctrl(8'h13);
        wr_len(8'h00);
        for (int i = 0; i < 5; i++) htick();
        push("len5", 3, 1'b1);
        cycle();
        u_bus.iWriteLength = 1'b1;
        u_bus.iData        = 8'h00;
        iHalfFrame         = 1'b1;
        cycle();
        u_bus.iWriteLength = 1'b0;
        iHalfFrame         = 1'b0;
        for (int i = 0; i < 9; i++) htick();
        push("coinc_after9", 3, 1'b1);
        cycle();
        htick();
        push("coinc_after10", 0, 1'b0);
        cycle();

        // Reset in the middle of a decay
        wr_ctrl(8'h03);
        wr_len(8'h08);
        qtick();
        qtick();
        push("pre_reset", 15, 1'b1);
        cycle();
        iReset        = 1'b1;
        iQuarterFrame = 1'b1;
        push("reset_mid", 0, 1'b0);
        cycle();
        iReset        = 1'b0;
        iQuarterFrame = 1'b0;
        push("post_reset_len", 0, 1'b0);
        cycle();
        wr_len(8'h08);
        push("post_reset_decay", 0, 1'b1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_envelope_length.md
Name: pulse_envelope_length

Overview:
Downstream neighbour of the pulse duty sequencer. Takes the sequencer's 1-bit duty output and produces the channel's 4-bit output sample. Volume comes from either a constant-volume register or a decaying envelope. A length counter mutes the channel when it expires. Quarter-frame and half-frame ticks come from the APU frame sequencer; register writes come from the CPU register decode.

Parameters:
LEN_W, 8, width of the length counter.
VOL_W, 4, width of the volume, decay level and divider.

Ports:
clk  input  1  system clock
iReset  input  1  synchronous active-high reset
iDuty  input  1  duty sequencer output bit (already gated by its own enable)
iEnable  input  1  channel enable from the status register; 0 forces the length counter to 0
iQuarterFrame  input  1  single-cycle pulse that clocks the envelope
iHalfFrame  input  1  single-cycle pulse that clocks the length counter
iWriteCtrl  input  1  single-cycle strobe: write control register from iData
iWriteLength  input  1  single-cycle strobe: length load / envelope restart from iData
iData  input  8  CPU write data
oSample  output  4  channel sample, 0..15
oLengthActive  output  1  1 when the length counter is nonzero (status read-back)

Behaviour:
- All state updates on posedge clk. iReset is synchronous and active-high. Reset clears ctrl_halt, ctrl_const, ctrl_vol, start_flag, divider, decay and length to 0, and drives oSample=0 and oLengthActive=0.
- On iWriteCtrl:
  - ctrl_halt <= iData[5] (length halt, also envelope loop).
  - ctrl_const <= iData[4].
  - ctrl_vol <= iData[3:0].
  - iData[7:6] (duty) is ignored here.
- On iWriteLength:
  - start_flag <= 1.
  - If iEnable=1: length <= LUT[iData[7:3]].
  - If iEnable=0: length is unchanged (stays 0).
  - The 32-entry LUT, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Envelope, evaluated only on iQuarterFrame:
  - If start_flag=1: start_flag <= 0, decay <= 15, divider <= ctrl_vol.
  - Else if divider==0: divider <= ctrl_vol. Then if decay!=0, decay <= decay-1. Else if ctrl_halt=1, decay <= 15 (loop wraps). Else decay holds at 0.
  - Else: divider <= divider-1.
- Length counter, evaluated only on iHalfFrame: if ctrl_halt=0 and length!=0, length <= length-1. It never wraps below 0.
- iEnable=0 forces length <= 0 every cycle. This overrides both loads and decrements.
- Simultaneous events:
  - iWriteLength with iHalfFrame: the load wins and no decrement is applied that cycle.
  - iWriteLength with iQuarterFrame: the envelope step uses the pre-write start_flag; start_flag ends the cycle at 1.
  - iWriteCtrl with a tick: the tick uses the old ctrl_* values.
- Output, registered with 1-cycle latency from the state and iDuty:
  - oSample <= (iDuty && length!=0) ? (ctrl_const ? ctrl_vol : decay) : 0.
  - oLengthActive <= (length!=0), with length being the current (pre-update) value.
- Reset mid-operation: all state returns to reset values on the next edge, and pending ticks in that cycle are discarded.

Test Plan:
- Reset, then iWriteCtrl with iData=8'h1A (const, vol 10), then iWriteLength with iData=8'h08 (index 1, len 254), iEnable=1, iDuty=1 -> oSample=10 and oLengthActive=1 one cycle later; iDuty=0 -> oSample=0 next cycle.
- iWriteCtrl 8'h03 (envelope mode, period 3, no loop), then iWriteLength, then repeated quarter ticks -> first tick sets decay=15; after that decay drops by 1 every 4 ticks to 0 and stays at 0; oSample tracks decay while iDuty=1.
- Same setup but iWriteCtrl 8'h20 (loop, period 0) -> decay steps 15,14,…,0,15 on consecutive quarter ticks.
- iWriteLength index 3 (len 2), halt=0, two half ticks -> oLengthActive falls to 0 and oSample=0 while iDuty=1. Repeat with halt=1 -> length stays at 2.
- iEnable=0 during a length write -> length stays 0 and oLengthActive=0. Deassert iEnable while length=254 -> oLengthActive=0 two cycles later.
- iWriteLength (index 0, len 10) coincident with iHalfFrame while length=5 -> length=10 with no decrement. Assert iReset mid-decay -> oSample=0 and oLengthActive=0 on the following cycle.
